// File: rtl/ramb_tdp_param.sv
// Parametrised true-dual-port block RAM with byte enables, per-port write modes,
// optional output registers, a clear sweep engine and a registered collision flag.
module ramb_tdp_param #(
  parameter int unsigned              ADDR_WIDTH   = 10,
  parameter int unsigned              DATA_WIDTH   = 32,
  parameter int unsigned              BYTE_WIDTH   = 8,
  parameter int unsigned              DOA_REG      = 0,
  parameter int unsigned              DOB_REG      = 0,
  parameter string                    WRITE_MODE_A = "WRITE_FIRST",
  parameter string                    WRITE_MODE_B = "WRITE_FIRST",
  parameter logic [DATA_WIDTH-1:0]    SRVAL_A      = '0,
  parameter logic [DATA_WIDTH-1:0]    SRVAL_B      = '0,
  parameter logic [DATA_WIDTH-1:0]    INIT_VALUE   = '0
) (
  input  logic                             CLK,
  input  logic                             SSR,
  input  logic                             CLR,
  input  logic                             ENA,
  input  logic                             ENB,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] WEA,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] WEB,
  input  logic [ADDR_WIDTH-1:0]            ADDRA,
  input  logic [ADDR_WIDTH-1:0]            ADDRB,
  input  logic [DATA_WIDTH-1:0]            DIA,
  input  logic [DATA_WIDTH-1:0]            DIB,
  input  logic                             REGCEA,
  input  logic                             REGCEB,
  output logic [DATA_WIDTH-1:0]            DOA,
  output logic [DATA_WIDTH-1:0]            DOB,
  output logic                             BUSY,
  output logic                             COLL
);

  localparam int unsigned NBYTE = DATA_WIDTH / BYTE_WIDTH;
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {WM_WF, WM_RF, WM_NC} wmode_t;
  typedef enum logic {IDLE, CLEAR} state_t;

  localparam wmode_t MODE_A = (WRITE_MODE_A == "READ_FIRST") ? WM_RF :
                              (WRITE_MODE_A == "NO_CHANGE")  ? WM_NC : WM_WF;
  localparam wmode_t MODE_B = (WRITE_MODE_B == "READ_FIRST") ? WM_RF :
                              (WRITE_MODE_B == "NO_CHANGE")  ? WM_NC : WM_WF;

  if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
    $error("ramb_tdp_param: DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t                state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic                  busy;
  logic                  ena_i, enb_i;
  logic                  wr_a, wr_b;
  logic                  coll_now;
  logic                  coll_q;
  logic [DATA_WIDTH-1:0] old_a, old_b;
  logic [DATA_WIDTH-1:0] merged_a, merged_b;
  logic [DATA_WIDTH-1:0] lat_a, lat_b;
  logic [DATA_WIDTH-1:0] oreg_a, oreg_b;

  assign busy  = (state == CLEAR);
  assign ena_i = ENA & ~busy & ~SSR;
  assign enb_i = ENB & ~busy & ~SSR;
  assign wr_a  = |WEA;
  assign wr_b  = |WEB;
  assign coll_now = ena_i & enb_i & (ADDRA == ADDRB) & (wr_a | wr_b);

  always_comb begin
    old_a    = mem[ADDRA];
    old_b    = mem[ADDRB];
    merged_a = old_a;
    merged_b = old_b;
    for (int unsigned i = 0; i < NBYTE; i++) begin
      if (WEA[i]) merged_a[i*BYTE_WIDTH +: BYTE_WIDTH] = DIA[i*BYTE_WIDTH +: BYTE_WIDTH];
      if (WEB[i]) merged_b[i*BYTE_WIDTH +: BYTE_WIDTH] = DIB[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  // During a collision every enabled port sees the pre-write word, whatever its mode.
  function automatic logic [DATA_WIDTH-1:0] port_next(
    input wmode_t                mode,
    input logic                  wr,
    input logic                  coll,
    input logic [DATA_WIDTH-1:0] cur,
    input logic [DATA_WIDTH-1:0] old,
    input logic [DATA_WIDTH-1:0] merged
  );
    if (coll || !wr) return old;
    case (mode)
      WM_RF:   return old;
      WM_NC:   return cur;
      default: return merged;
    endcase
  endfunction

  // Port A lanes are written last so they win over port B on a shared address.
  always_ff @(posedge CLK) begin
    if (busy && !SSR) mem[cnt] <= INIT_VALUE;
    for (int unsigned i = 0; i < NBYTE; i++) begin
      if (enb_i && WEB[i]) mem[ADDRB][i*BYTE_WIDTH +: BYTE_WIDTH] <= DIB[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
    for (int unsigned i = 0; i < NBYTE; i++) begin
      if (ena_i && WEA[i]) mem[ADDRA][i*BYTE_WIDTH +: BYTE_WIDTH] <= DIA[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  always_ff @(posedge CLK) begin
    if (SSR) begin
      state  <= CLEAR;
      cnt    <= '0;
      coll_q <= 1'b0;
      lat_a  <= SRVAL_A;
      lat_b  <= SRVAL_B;
      oreg_a <= SRVAL_A;
      oreg_b <= SRVAL_B;
    end else begin
      case (state)
        IDLE:    if (CLR) state <= CLEAR;
        CLEAR: begin
          cnt <= cnt + ADDR_WIDTH'(1);
          if (cnt == '1) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      coll_q <= coll_now;
      if (ena_i) lat_a <= port_next(MODE_A, wr_a, coll_now, lat_a, old_a, merged_a);
      if (enb_i) lat_b <= port_next(MODE_B, wr_b, coll_now, lat_b, old_b, merged_b);
      if (REGCEA) oreg_a <= lat_a;
      if (REGCEB) oreg_b <= lat_b;
    end
  end

  assign DOA  = (DOA_REG != 0) ? oreg_a : lat_a;
  assign DOB  = (DOB_REG != 0) ? oreg_b : lat_b;
  assign BUSY = busy;
  assign COLL = coll_q;

endmodule

// File: tb/tb_ramb_tdp_param.sv
// Scoreboard bench for ramb_tdp_param: stimulus queues expected values per cycle,
// a negedge monitor pops and compares them against two differently-configured instances.
module tb_ramb_tdp_param;

  logic        clk;
  logic        ssr, clr;
  logic        ena, enb;
  logic [1:0]  wea, web;
  logic [3:0]  addra, addrb;
  logic [15:0] dia, dib;
  logic        regcea, regceb;
  logic [15:0] doa, dob, wdoa, wdob;
  logic        busy, coll, wbusy, wcoll;

  ramb_tdp_param #(
    .ADDR_WIDTH(4), .DATA_WIDTH(16), .BYTE_WIDTH(8),
    .DOA_REG(0), .DOB_REG(1),
    .WRITE_MODE_A("READ_FIRST"), .WRITE_MODE_B("NO_CHANGE"),
    .SRVAL_A(16'h1234), .SRVAL_B(16'h5678), .INIT_VALUE(16'hA5A5)
  ) u_dut (
    .CLK(clk), .SSR(ssr), .CLR(clr), .ENA(ena), .ENB(enb), .WEA(wea), .WEB(web),
    .ADDRA(addra), .ADDRB(addrb), .DIA(dia), .DIB(dib), .REGCEA(regcea), .REGCEB(regceb),
    .DOA(doa), .DOB(dob), .BUSY(busy), .COLL(coll)
  );

  ramb_tdp_param #(
    .ADDR_WIDTH(4), .DATA_WIDTH(16), .BYTE_WIDTH(8),
    .DOA_REG(0), .DOB_REG(0),
    .WRITE_MODE_A("WRITE_FIRST"), .WRITE_MODE_B("WRITE_FIRST"),
    .SRVAL_A(16'h0000), .SRVAL_B(16'h0000), .INIT_VALUE(16'h0F0F)
  ) u_wf (
    .CLK(clk), .SSR(ssr), .CLR(clr), .ENA(ena), .ENB(enb), .WEA(wea), .WEB(web),
    .ADDRA(addra), .ADDRB(addrb), .DIA(dia), .DIB(dib), .REGCEA(regcea), .REGCEB(regceb),
    .DOA(wdoa), .DOB(wdob), .BUSY(wbusy), .COLL(wcoll)
  );

  localparam int S_DOA = 0, S_DOB = 1, S_BUSY = 2, S_COLL = 3, S_WDOA = 4, S_WDOB = 5;

  typedef struct {
    int unsigned when;
    int          sig;
    logic [15:0] exp;
    string       name;
  } chk_t;

  chk_t        q[$];
  int unsigned cyc = 0;
  int          total = 0;
  int          bad = 0;
  logic [15:0] mon_act;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] sample(input int sig);
    case (sig)
      S_DOA:   return doa;
      S_DOB:   return dob;
      S_BUSY:  return {15'd0, busy};
      S_COLL:  return {15'd0, coll};
      S_WDOA:  return wdoa;
      default: return wdob;
    endcase
  endfunction

  task automatic want(input int unsigned d, input int sig, input logic [15:0] v, input string nm);
    chk_t c;
    c.when = cyc + d;
    c.sig  = sig;
    c.exp  = v;
    c.name = nm;
    q.push_back(c);
  endtask

  always @(negedge clk) begin
    for (int i = int'(q.size()) - 1; i >= 0; i--) begin
      if (q[i].when == cyc) begin
        mon_act = sample(q[i].sig);
        total++;
        if (mon_act !== q[i].exp) begin
          bad++;
          $display("FAIL %s: got %h want %h (cycle %0d)", q[i].name, mon_act, q[i].exp, cyc);
        end
        q.delete(i);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    if (busy) begin
      total++;
      bad++;
      $display("FAIL busy_timeout: got busy=1 want busy=0 after %0d cycles", n);
    end
  endtask

  initial begin
    ssr = 1'b1; clr = 1'b0; ena = 1'b0; enb = 1'b0; wea = '0; web = '0;
    addra = '0; addrb = '0; dia = '0; dib = '0; regcea = 1'b1; regceb = 1'b1;

    // reset state and sweep length
    tick(); tick();
    want(0, S_DOA, 16'h1234, "rst_doa");
    want(0, S_DOB, 16'h5678, "rst_dob");
    want(0, S_BUSY, 16'd1, "rst_busy");
    want(0, S_COLL, 16'd0, "rst_coll");
    want(0, S_WDOA, 16'h0000, "rst_wdoa");
    ssr = 1'b0;
    want(15, S_BUSY, 16'd1, "busy_last");
    want(16, S_BUSY, 16'd0, "busy_fall");
    want(16, S_DOB, 16'h5678, "dob_hold_sweep");
    wait_idle();

    // every word holds INIT_VALUE
    for (int a = 0; a < 16; a++) begin
      ena = 1'b1; enb = 1'b1; addra = 4'(a); addrb = 4'(a);
      want(1, S_DOA, 16'hA5A5, "init_a");
      want(2, S_DOB, 16'hA5A5, "init_b");
      want(1, S_WDOA, 16'h0F0F, "init_wa");
      want(1, S_WDOB, 16'h0F0F, "init_wb");
      tick();
    end
    ena = 1'b0; enb = 1'b0;
    tick();

    // byte write on A
    ena = 1'b1; wea = 2'b01; addra = 4'd3; dia = 16'hBEEF;
    want(1, S_DOA, 16'hA5A5, "bytewr_rf_a");
    want(1, S_WDOA, 16'h0FEF, "bytewr_wf_a");
    tick();
    wea = 2'b00; enb = 1'b1; addrb = 4'd3;
    want(1, S_DOA, 16'hA5EF, "byterd_a");
    want(2, S_DOB, 16'hA5EF, "byterd_b");
    want(1, S_WDOA, 16'h0FEF, "byterd_wa");
    want(1, S_WDOB, 16'h0FEF, "byterd_wb");
    tick();
    enb = 1'b0;

    // write modes at address 5
    wea = 2'b11; addra = 4'd5; dia = 16'h1111;
    want(1, S_DOA, 16'hA5A5, "rf_full_a");
    want(1, S_WDOA, 16'h1111, "wf_full_a");
    tick();
    ena = 1'b0; wea = 2'b00;
    enb = 1'b1; web = 2'b11; addrb = 4'd5; dib = 16'h1111;
    want(1, S_DOB, 16'hA5EF, "nc_hold_b1");
    want(2, S_DOB, 16'hA5EF, "nc_hold_b2");
    want(1, S_WDOB, 16'h1111, "wf_full_b");
    tick();
    enb = 1'b0; web = 2'b00;
    ena = 1'b1; addra = 4'd5;
    want(1, S_DOA, 16'h1111, "mode_rd_a");
    tick();

    // collision at address 7
    ena = 1'b1; enb = 1'b1; addra = 4'd7; addrb = 4'd7;
    dia = 16'h00FF; wea = 2'b01; dib = 16'hFF00; web = 2'b11;
    want(1, S_COLL, 16'd1, "coll_set");
    want(2, S_COLL, 16'd0, "coll_clear");
    tick();
    wea = 2'b00; web = 2'b00;
    want(1, S_DOA, 16'hFFFF, "coll_rd_a");
    want(2, S_DOB, 16'hFFFF, "coll_rd_b");
    want(1, S_WDOA, 16'hFFFF, "coll_rd_wa");
    tick();
    ena = 1'b0; enb = 1'b0;
    tick();

    // output register clock enable
    enb = 1'b1; addrb = 4'd5; regceb = 1'b0;
    want(1, S_DOB, 16'hFFFF, "regce_hold1");
    want(2, S_DOB, 16'hFFFF, "regce_hold2");
    tick();
    enb = 1'b0;
    tick();
    regceb = 1'b1;
    want(1, S_DOB, 16'h1111, "regce_load");
    tick();

    // CLR sweep: writes discarded, CLR mid-sweep ignored
    clr = 1'b1;
    tick();
    clr = 1'b0;
    want(0, S_BUSY, 16'd1, "clr_busy");
    want(15, S_BUSY, 16'd1, "clr_busy_last");
    want(16, S_BUSY, 16'd0, "clr_busy_fall");
    ena = 1'b1; wea = 2'b11; addra = 4'd9; dia = 16'hDEAD;
    want(1, S_DOA, 16'hFFFF, "busy_hold_a");
    want(1, S_WDOA, 16'hFFFF, "busy_hold_wa");
    tick();
    ena = 1'b0; wea = 2'b00;
    tick(); tick(); tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    wait_idle();
    ena = 1'b1; addra = 4'd9; enb = 1'b1; addrb = 4'd5;
    want(1, S_DOA, 16'hA5A5, "busy_wr_lost");
    want(1, S_WDOA, 16'h0F0F, "busy_wr_lost_w");
    want(2, S_DOB, 16'hA5A5, "reclear_b");
    tick();
    ena = 1'b0; enb = 1'b0;
    tick();

    // SSR mid-sweep restarts from address 0
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick(); tick(); tick(); tick();
    ssr = 1'b1;
    tick();
    ssr = 1'b0;
    want(0, S_DOA, 16'h1234, "ssr_mid_doa");
    want(0, S_DOB, 16'h5678, "ssr_mid_dob");
    want(0, S_WDOA, 16'h0000, "ssr_mid_wdoa");
    want(15, S_BUSY, 16'd1, "ssr_mid_busy");
    want(16, S_BUSY, 16'd0, "ssr_mid_fall");
    wait_idle();

    tick(); tick(); tick();
    while (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL %s: got unchecked want checked (due cycle %0d)", q[0].name, q[0].when);
      void'(q.pop_front());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
